// File: rtl/word_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_pkg - shared word type, writer FSM states and bank reset word   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package word_pkg;

   localparam int NIBBLE_W = 4;
   localparam int NIBBLES  = 8;

   typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_COMMIT  = 2'd2
   } wr_state_t;

   localparam word_t RESET_WORD = 32'h89AB_CDEF;

endpackage
`default_nettype wire

// File: rtl/word_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_bank - DEPTH packed words, one write port, combinational read   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module word_bank
   import word_pkg::*;
#(
   parameter int NIBBLES  = word_pkg::NIBBLES,
   parameter int NIBBLE_W = word_pkg::NIBBLE_W,
   parameter int DEPTH    = 16,
   parameter int AW       = 11,
   parameter logic [NIBBLES*NIBBLE_W-1:0] RESET_WORD = word_pkg::RESET_WORD
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              we,
   input  logic [AW-1:0]                     waddr,
   input  logic [NIBBLES-1:0][NIBBLE_W-1:0]  wdata,
   input  logic [AW-1:0]                     rd_addr,
   output logic [NIBBLES-1:0][NIBBLE_W-1:0]  rd_data
);

   localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] c_depth = AW'(DEPTH);

   logic [NIBBLES-1:0][NIBBLE_W-1:0] w_mem [DEPTH];
   logic                             w_wr_in_range;
   logic                             w_rd_in_range;

   assign w_wr_in_range = (waddr < c_depth);
   assign w_rd_in_range = (rd_addr < c_depth);

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_entry
         localparam logic [NIBBLES-1:0][NIBBLE_W-1:0] c_init =
            (i == 0) ? RESET_WORD : '0;

         logic [NIBBLES-1:0][NIBBLE_W-1:0] r_word;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_word <= c_init;
            end else if (we && w_wr_in_range && (waddr == AW'(i))) begin
               r_word <= wdata;
            end
         end

         assign w_mem[i] = r_word;
      end
   endgenerate

   // Out-of-range reads never reach the index, so a non-power-of-2 DEPTH is safe.
   assign rd_data = w_rd_in_range ? w_mem[rd_addr[IW-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/nibble_word_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_word_writer - assembles nibble streams into bank word writes  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nibble_word_writer
   import word_pkg::*;
#(
   parameter int NIBBLES  = word_pkg::NIBBLES,
   parameter int NIBBLE_W = word_pkg::NIBBLE_W,
   parameter int DEPTH    = 16,
   parameter int AW       = 11,
   parameter logic [NIBBLES*NIBBLE_W-1:0] RESET_WORD = word_pkg::RESET_WORD
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start_valid,
   input  logic [AW-1:0]                     start_addr,
   output logic                              start_ready,
   input  logic                              nib_valid,
   input  logic [NIBBLE_W-1:0]               nib_data,
   output logic                              nib_ready,
   input  logic                              abort,
   output logic                              done,
   output logic                              err,
   input  logic [AW-1:0]                     rd_addr,
   output logic [NIBBLES-1:0][NIBBLE_W-1:0]  rd_data
);

   localparam int            CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] c_last  = CW'(NIBBLES - 1);
   localparam logic [AW-1:0] c_depth = AW'(DEPTH);

   wr_state_t                        r_state;
   logic [AW-1:0]                    r_addr;
   logic [CW-1:0]                    r_cnt;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] r_asm;
   logic                             r_start_ready;
   logic                             r_nib_ready;
   logic                             r_done;
   logic                             r_err;

   logic                             w_in_range;
   logic                             w_we;

   assign w_in_range = (r_addr < c_depth);
   assign w_we       = (r_state == ST_COMMIT) && w_in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_addr        <= '0;
         r_cnt         <= '0;
         r_asm         <= '0;
         r_start_ready <= 1'b1;
         r_nib_ready   <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_valid && r_start_ready) begin
                  r_addr        <= start_addr;
                  r_asm         <= '0;
                  r_cnt         <= '0;
                  r_start_ready <= 1'b0;
                  r_nib_ready   <= 1'b1;
                  r_state       <= ST_COLLECT;
               end
            end

            ST_COLLECT: begin
               // Abort takes priority even over the final nibble handshake.
               if (abort) begin
                  r_cnt         <= '0;
                  r_start_ready <= 1'b1;
                  r_nib_ready   <= 1'b0;
                  r_state       <= ST_IDLE;
               end else if (nib_valid && r_nib_ready) begin
                  r_asm[r_cnt] <= nib_data;
                  if (r_cnt == c_last) begin
                     r_cnt       <= '0;
                     r_nib_ready <= 1'b0;
                     r_done      <= w_in_range;
                     r_err       <= !w_in_range;
                     r_state     <= ST_COMMIT;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end

            ST_COMMIT: begin
               r_done        <= 1'b0;
               r_err         <= 1'b0;
               r_start_ready <= 1'b1;
               r_state       <= ST_IDLE;
            end

            default: begin
               r_cnt         <= '0;
               r_done        <= 1'b0;
               r_err         <= 1'b0;
               r_start_ready <= 1'b1;
               r_nib_ready   <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign start_ready = r_start_ready;
   assign nib_ready   = r_nib_ready;
   assign done        = r_done;
   assign err         = r_err;

   word_bank #(
      .NIBBLES    (NIBBLES),
      .NIBBLE_W   (NIBBLE_W),
      .DEPTH      (DEPTH),
      .AW         (AW),
      .RESET_WORD (RESET_WORD)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (w_we),
      .waddr   (r_addr),
      .wdata   (r_asm),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_nibble_word_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nibble_word_writer - directed self-checking bench                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nibble_word_writer;

   localparam int AW    = 11;
   localparam int DEPTH = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start_valid = 1'b0;
   logic [AW-1:0]       start_addr = '0;
   logic                start_ready;
   logic                nib_valid = 1'b0;
   logic [3:0]          nib_data = '0;
   logic                nib_ready;
   logic                abort = 1'b0;
   logic                done;
   logic                err;
   logic [AW-1:0]       rd_addr = '0;
   logic [7:0][3:0]     rd_data;

   int                  n_checks = 0;
   int                  n_fail = 0;
   int                  cyc = 0;
   int                  c0;
   logic [31:0]         exp_bank [DEPTH];

   always #5 clk = ~clk;

   nibble_word_writer #(
      .NIBBLES (8), .NIBBLE_W (4), .DEPTH (DEPTH), .AW (AW),
      .RESET_WORD (32'h89AB_CDEF)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .start_valid (start_valid), .start_addr (start_addr), .start_ready (start_ready),
      .nib_valid (nib_valid), .nib_data (nib_data), .nib_ready (nib_ready),
      .abort (abort), .done (done), .err (err),
      .rd_addr (rd_addr), .rd_data (rd_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic rd_check(input string tag, input int addr, input logic [31:0] exp);
      rd_addr = AW'(addr);
      #1;
      check(tag, rd_data, exp);
   endtask

   task automatic bank_check(input string tag);
      for (int i = 0; i < DEPTH; i++) rd_check(tag, i, exp_bank[i]);
   endtask

   task automatic start(input int addr);
      start_valid = 1'b1;
      start_addr  = AW'(addr);
      step();
      start_valid = 1'b0;
   endtask

   task automatic send(input logic [3:0] v);
      nib_valid = 1'b1;
      nib_data  = v;
      step();
      nib_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) exp_bank[i] = 32'h0;
      exp_bank[0] = 32'h89AB_CDEF;

      // Reset state
      #12 rst_n = 1'b1;
      step();
      rd_check("rst_rd0", 0, 32'h89AB_CDEF);
      rd_check("rst_rd5", 5, 32'h0);
      check("rst_start_ready", start_ready, 1);
      check("rst_nib_ready", nib_ready, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);

      // Back-to-back write to address 3
      start(3);
      check("t2_nib_ready", nib_ready, 1);
      check("t2_start_ready", start_ready, 0);
      c0 = cyc;
      begin
         logic [31:0] seq;
         seq = 32'h89AB_CDEF;
         for (int i = 0; i < 8; i++) begin
            nib_valid = 1'b1;
            nib_data  = seq[4*i +: 4];
            step();
         end
         nib_valid = 1'b0;
      end
      check("t2_latency", cyc - c0, 8);
      check("t2_done", done, 1);
      check("t2_err", err, 0);
      check("t2_nib_ready_commit", nib_ready, 0);
      rd_check("t2_rd_old", 3, 32'h0);
      step();
      exp_bank[3] = 32'h89AB_CDEF;
      rd_check("t2_rd_new", 3, 32'h89AB_CDEF);
      check("t2_done_pulse", done, 0);
      check("t2_idle_ready", start_ready, 1);

      // Stalled nibble stream to address 1; abort during COMMIT is ignored
      start(1);
      c0 = cyc;
      for (int i = 1; i <= 4; i++) send(4'(i));
      step(); step(); step();
      check("t3_hold_ready", nib_ready, 1);
      for (int i = 5; i <= 7; i++) send(4'(i));
      check("t3_no_early_done", done, 0);
      send(4'd8);
      check("t3_latency", cyc - c0, 11);
      check("t3_done", done, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      exp_bank[1] = 32'h8765_4321;
      rd_check("t3_rd1", 1, 32'h8765_4321);

      // Abort after 5 nibbles at address 2
      start(2);
      for (int i = 0; i < 5; i++) send(4'hA);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t4_start_ready", start_ready, 1);
      check("t4_nib_ready", nib_ready, 0);
      check("t4_done", done, 0);
      check("t4_err", err, 0);
      step();
      check("t4_quiet_done", done, 0);
      check("t4_quiet_err", err, 0);
      rd_check("t4_rd2", 2, 32'h0);

      // Immediate restart; abort coinciding with the final nibble wins
      start(6);
      check("t4b_accepted", nib_ready, 1);
      for (int i = 0; i < 7; i++) send(4'h5);
      abort = 1'b1;
      send(4'h5);
      abort = 1'b0;
      check("t4b_idle", start_ready, 1);
      check("t4b_done", done, 0);
      step();
      check("t4b_done_late", done, 0);
      rd_check("t4b_rd6", 6, 32'h0);

      // Out-of-range address
      start(20);
      for (int i = 0; i < 8; i++) send(4'hC);
      check("t5_err", err, 1);
      check("t5_done", done, 0);
      step();
      check("t5_err_pulse", err, 0);
      check("t5_done_after", done, 0);
      rd_check("t5_rd20", 20, 32'h0);
      bank_check("t5_bank");

      // Reset mid-COLLECT at address 4
      start(4);
      for (int i = 0; i < 6; i++) send(4'h7);
      #2 rst_n = 1'b0;
      #1;
      check("t6_start_ready", start_ready, 1);
      check("t6_nib_ready", nib_ready, 0);
      check("t6_done", done, 0);
      check("t6_err", err, 0);
      for (int i = 1; i < DEPTH; i++) exp_bank[i] = 32'h0;
      rd_check("t6_rd4", 4, 32'h0);
      rd_check("t6_rd1", 1, 32'h0);
      rd_check("t6_rd0", 0, 32'h89AB_CDEF);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reset during COMMIT loses the pending write
      start(5);
      for (int i = 0; i < 8; i++) send(4'h3);
      check("t7_done", done, 1);
      #1 rst_n = 1'b0;
      #1;
      check("t7_done_rst", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      rd_check("t7_rd5", 5, 32'h0);
      bank_check("t7_bank");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nibble_word_writer.md
# nibble_word_writer

Write-side counterpart of the packed-word lookup path: it accepts a target address, collects a 32-bit word as eight 4-bit nibbles over a valid/ready stream, and commits the assembled packed word (`[7:0][3:0]`) into a small word bank. A combinational read port returns `word(address)` from the same bank, so the write and read ends of the word interface live in one block between the config loader and the word consumers.

## Interface
- `NIBBLES`, 8, nibble lanes per word (packed outer dimension).
- `NIBBLE_W`, 4, bits per nibble lane (packed inner dimension).
- `DEPTH`, 16, number of words in the bank.
- `AW`, 11, address width on both write and read ports.
- `RESET_WORD`, 32'h89_AB_CD_EF, reset content of entry 0; all other entries reset to 0.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_valid`  in  1  request to begin a word write.
- `start_addr`  in  AW  target word address, sampled on the start handshake.
- `start_ready`  out  1  high only in IDLE.
- `nib_valid`  in  1  nibble present.
- `nib_data`  in  NIBBLE_W  nibble value.
- `nib_ready`  out  1  high only in COLLECT.
- `abort`  in  1  discard the word being collected.
- `done`  out  1  one-cycle pulse: word committed.
- `err`  out  1  one-cycle pulse: address out of range, commit suppressed.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  [NIBBLES-1:0][NIBBLE_W-1:0]  bank word at `rd_addr`; 0 when `rd_addr` >= DEPTH.

## Operation
- FSM states: IDLE, COLLECT, COMMIT.
- IDLE: `start_valid && start_ready` latches `start_addr`, clears the assembly register and lane counter, and moves to COLLECT.
- COLLECT: each `nib_valid && nib_ready` writes `nib_data` into lane `cnt`, then increments `cnt`. Lane 0 (bits 3:0) is filled first, so the least-significant nibble arrives first. Acceptance of lane NIBBLES-1 moves to COMMIT.
- `nib_valid` low in COLLECT: the FSM holds state; there is no timeout.
- `abort` high in COLLECT: the FSM returns to IDLE, the bank is untouched and neither `done` nor `err` fires. If `abort` and the final nibble handshake coincide, abort wins.
- `abort` is ignored in IDLE and COMMIT.
- COMMIT, address < DEPTH: `bank[addr]` takes the assembled word, `done` is 1 for this cycle, then the FSM goes to IDLE.
- COMMIT, address >= DEPTH: no write, `err` is 1 for this cycle, then the FSM goes to IDLE.
- The lane counter is log2(NIBBLES) bits wide and wraps only through the state change. It never indexes past lane NIBBLES-1.
- Read port: `rd_data` is purely combinational from the bank.
- Read and commit to the same address in the same cycle: `rd_data` shows the old word in that cycle and the new word from the next cycle.

## Timing
- Reset values:
  - state IDLE; `start_ready` 1; `nib_ready` 0; `done` 0; `err` 0; `cnt` 0; assembly register 0.
  - bank[0] = RESET_WORD, all other entries 0, so `rd_data` at address 0 reads 32'h89ABCDEF.
- Back-to-back flow: start handshake in cycle 0; nibbles in cycles 1–8; COMMIT in cycle 9 with `done`/`err` high; IDLE with `start_ready` high in cycle 10.
- Latency from the last nibble handshake to `done` is 1 cycle. Minimum spacing between starts is 10 cycles.
- `rst_n` falling at any point, including mid-COLLECT or in COMMIT, immediately forces the reset values, including the bank. A pending commit is lost.

## Structure
- Package `word_pkg` holds:
  - `NIBBLE_W` and `NIBBLES` defaults;
  - `typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] word_t`;
  - FSM state enum `wr_state_t`;
  - `RESET_WORD` constant.
- Sub-module `word_bank`: DEPTH × word_t registers with async reset (entry 0 = RESET_WORD), one write port (`we`, `waddr`, `wdata`) and one combinational read port with out-of-range read returning 0.
- `nibble_word_writer` contains the FSM, lane counter and assembly register, and instantiates `word_bank`.

## Test plan
- Reset release, then `rd_addr`=0 → `rd_data`=32'h89ABCDEF; `rd_addr`=5 → 0; `start_ready`=1, `nib_ready`=0.
- Start addr 3, nibbles F,E,D,C,B,A,9,8 back-to-back → `done` in cycle 9; `rd_addr`=3 gives 32'h89ABCDEF from cycle 10, and the same read in cycle 9 gives 0.
- Start addr 1 with `nib_valid` deasserted for 3 cycles after the 4th nibble, nibbles 1..8 → `done` 3 cycles later than back-to-back; bank[1]=32'h87654321.
- Start addr 2, 5 nibbles, then `abort` → IDLE next cycle, no `done`/`err`, bank[2] stays 0; an immediate new start is accepted.
- Start addr 20 (>= DEPTH), 8 nibbles → `err` pulse for 1 cycle, no `done`, all bank entries unchanged.
- Start addr 4, `rst_n` low after the 6th nibble → all outputs at reset values asynchronously; bank[4]=0, bank[0]=32'h89ABCDEF.
